// File: rtl/sysahb_pkg.sv
// sysahb_pkg: shared AHB-Lite encodings, default system map and decode helper
package sysahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;
    localparam logic [31:0] BRAM_BASE = 32'h2000_0000;
    localparam logic [31:0] BRAM_MASK = 32'hFF80_0000;
    localparam logic [31:0] APB_BASE  = 32'h4000_0000;
    localparam logic [31:0] APB_MASK  = 32'hF000_0000;
    typedef enum logic [1:0] {ERR_IDLE, ERR_FIRST, ERR_SECOND} err_state_e;
    function automatic logic region_hit(logic [31:0] addr, logic [31:0] base, logic [31:0] mask);
        return (addr & mask) == base;
    endfunction
endpackage

// File: rtl/sysahb_slave_fabric_if.sv
// sysahb_slave_fabric_if: master-side AHB bus plus per-slave select/response bundle
interface sysahb_slave_fabric_if #(parameter int NUM_SLAVES = 4, parameter int DATA_W = 32);
    logic [31:0]                  sysahb_haddr;
    logic [1:0]                   sysahb_htrans;
    logic                         sysahb_hready;
    logic                         sysahb_hresp;
    logic [DATA_W-1:0]            sysahb_hrdata;
    logic [NUM_SLAVES-1:0]        hsel_s;
    logic [NUM_SLAVES-1:0]        hreadyout_s;
    logic [NUM_SLAVES-1:0]        hresp_s;
    logic [NUM_SLAVES*DATA_W-1:0] hrdata_s;
    logic                         fault_clr;
    logic [NUM_SLAVES-1:0]        fault_mask;
    logic                         timeout_irq;
    modport slave (
        input  sysahb_haddr, sysahb_htrans, hreadyout_s, hresp_s, hrdata_s, fault_clr,
        output sysahb_hready, sysahb_hresp, sysahb_hrdata, hsel_s, fault_mask, timeout_irq
    );
    modport master (
        output sysahb_haddr, sysahb_htrans, hreadyout_s, hresp_s, hrdata_s, fault_clr,
        input  sysahb_hready, sysahb_hresp, sysahb_hrdata, hsel_s, fault_mask, timeout_irq
    );
endinterface

// File: rtl/sysahb_err_resp.sv
// sysahb_err_resp: two-cycle AHB ERROR response sequencer
module sysahb_err_resp
    import sysahb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic hready,
    output logic hresp
);
    err_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        state_q <= rst ? ERR_IDLE : state_d;
    end

    always_comb begin
        state_d = start ? ERR_FIRST : (state_q == ERR_FIRST ? ERR_SECOND : ERR_IDLE);
        hready  = state_q != ERR_FIRST;
        hresp   = state_q != ERR_IDLE ? RESP_ERROR : RESP_OKAY;
    end
endmodule

// File: rtl/sysahb_slave_fabric.sv
// sysahb_slave_fabric: AHB-Lite decoder, response mux, default slave and stall watchdog
module sysahb_slave_fabric
    import sysahb_pkg::*;
#(
    parameter int                          NUM_SLAVES     = 4,
    parameter int                          DATA_W         = 32,
    parameter logic [NUM_SLAVES*32-1:0]    REGION_BASE    = '0,
    parameter logic [NUM_SLAVES*32-1:0]    REGION_MASK    = '0,
    parameter int                          TIMEOUT_CYCLES = 256
) (
    input logic                  sys_clk,
    input logic                  sys_reset,
    sysahb_slave_fabric_if.slave bus
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [NUM_SLAVES-1:0] hsel, dsel, fault_mask;
    logic                  dsel_def, taken, active, hready;
    logic                  sel_ready, sel_resp, err_ready, err_resp;
    logic                  stall, timeout, err_start, irq;
    logic [DATA_W-1:0]     sel_rdata;
    logic [CW-1:0]         cnt;

    // first matching region owns the address; a masked owner falls through to the default slave
    always_comb begin
        hsel  = '0;
        taken = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!taken && region_hit(bus.sysahb_haddr, REGION_BASE[i*32 +: 32], REGION_MASK[i*32 +: 32])) begin
                hsel[i] = ~fault_mask[i];
                taken   = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ready = 1'b1;
        sel_resp  = RESP_OKAY;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel[i]) begin
                sel_ready = bus.hreadyout_s[i];
                sel_resp  = bus.hresp_s[i];
                sel_rdata = bus.hrdata_s[i*DATA_W +: DATA_W];
            end
        end
    end

    assign active    = bus.sysahb_htrans == HTRANS_NONSEQ || bus.sysahb_htrans == HTRANS_SEQ;
    assign hready    = dsel_def ? err_ready : sel_ready;
    assign stall     = TIMEOUT_CYCLES != 0 && |dsel && !sel_ready;
    assign timeout   = stall && cnt == CNT_LAST;
    assign err_start = timeout || (hready && active && !(|hsel));

    sysahb_err_resp u_err (
        .clk    (sys_clk),
        .rst    (sys_reset),
        .start  (err_start),
        .hready (err_ready),
        .hresp  (err_resp)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            dsel       <= '0;
            dsel_def   <= 1'b0;
            cnt        <= '0;
            fault_mask <= '0;
            irq        <= 1'b0;
        end else begin
            fault_mask <= (bus.fault_clr ? '0 : fault_mask) | (timeout ? dsel : '0);
            irq        <= timeout;
            cnt        <= stall && !timeout ? cnt + CW'(1) : '0;
            if (timeout) begin
                dsel     <= '0;
                dsel_def <= 1'b1;
            end else if (hready) begin
                dsel     <= hsel;
                dsel_def <= active && !(|hsel);
            end
        end
    end

    assign bus.sysahb_hready = hready;
    assign bus.sysahb_hresp  = dsel_def ? err_resp : sel_resp;
    assign bus.sysahb_hrdata = dsel_def ? '0 : sel_rdata;
    assign bus.hsel_s        = hsel;
    assign bus.fault_mask    = fault_mask;
    assign bus.timeout_irq   = irq;
endmodule
